// File: rtl/store_queue_fwd.sv
// Store queue with in-order commit/drain and combinational store-to-load forwarding.
// Entries are tracked with head/cmt/tail pointers that carry a wrap bit.
module store_queue_fwd #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int MASK_WIDTH = DATA_WIDTH / 8,
  localparam int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  backend_flush,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [PTR_WIDTH-1:0]  alloc_ptr,
  input  logic                  agu_valid,
  input  logic [PTR_WIDTH-1:0]  agu_ptr,
  input  logic [ADDR_WIDTH-1:0] agu_addr,
  input  logic [DATA_WIDTH-1:0] agu_wdata,
  input  logic [MASK_WIDTH-1:0] agu_wmask,
  input  logic                  commit_valid,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [MASK_WIDTH-1:0] ld_rmask,
  input  logic [PTR_WIDTH-1:0]  ld_ptr,
  output logic                  ld_fwd_hit,
  output logic [DATA_WIDTH-1:0] ld_fwd_data,
  output logic                  ld_stall,
  output logic                  dmem_req,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [MASK_WIDTH-1:0] dmem_wmask,
  input  logic                  dmem_resp,
  output logic                  empty
);
  localparam int IDX_W = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] FULL_XOR = PTR_ONE << IDX_W;

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_CMT} ent_state_e;

  ent_state_e            state_q [DEPTH];
  ent_state_e            state_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_d  [DEPTH];
  logic [MASK_WIDTH-1:0] mask_q  [DEPTH];
  logic [MASK_WIDTH-1:0] mask_d  [DEPTH];
  logic [PTR_WIDTH-1:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;

  logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx, agu_idx;
  logic             full, alloc_fire, drain_fire;
  logic             unused_bits;

  assign head_idx    = head_q[IDX_W-1:0];
  assign cmt_idx     = cmt_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign agu_idx     = agu_ptr[IDX_W-1:0];
  assign unused_bits = ^{ld_addr[1:0], agu_ptr[IDX_W]};

  assign full        = (tail_q ^ head_q) == FULL_XOR;
  assign empty       = (tail_q == head_q);
  assign alloc_ready = !full && !backend_flush;
  assign alloc_ptr   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign dmem_req    = (state_q[head_idx] == S_CMT);
  assign dmem_addr   = addr_q[head_idx];
  assign dmem_wdata  = data_q[head_idx];
  assign dmem_wmask  = mask_q[head_idx];
  assign drain_fire  = dmem_req && dmem_resp;

  // Updates are layered so that a same-cycle commit lands before the flush scrubs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    head_d  = head_q;
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    if (agu_valid) begin
      state_d[agu_idx] = S_READY;
      addr_d[agu_idx]  = agu_addr;
      data_d[agu_idx]  = agu_wdata;
      mask_d[agu_idx]  = agu_wmask;
    end
    if (commit_valid) begin
      state_d[cmt_idx] = S_CMT;
      cmt_d            = cmt_q + PTR_ONE;
    end
    if (drain_fire) begin
      state_d[head_idx] = S_FREE;
      head_d            = head_q + PTR_ONE;
    end
    if (alloc_fire) begin
      state_d[tail_idx] = S_WAIT;
      tail_d            = tail_q + PTR_ONE;
    end
    if (backend_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_d[i] == S_WAIT || state_d[i] == S_READY) state_d[i] = S_FREE;
      end
      tail_d = cmt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= S_FREE;
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    mask_q <= mask_d;
  end

  // Walk oldest to youngest from head; later matches override, leaving the youngest.
  logic [PTR_WIDTH-1:0]  ld_dist, pos;
  logic [IDX_W-1:0]      idx;
  logic                  any_wait, match;
  logic [MASK_WIDTH-1:0] match_mask;
  logic [DATA_WIDTH-1:0] match_data;

  always_comb begin
    ld_dist    = ld_ptr - head_q;
    pos        = head_q;
    idx        = head_idx;
    any_wait   = 1'b0;
    match      = 1'b0;
    match_mask = '0;
    match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos = head_q + PTR_WIDTH'(i);
      idx = pos[IDX_W-1:0];
      if (PTR_WIDTH'(i) < ld_dist) begin
        if (state_q[idx] == S_WAIT) any_wait = 1'b1;
        if ((state_q[idx] == S_READY || state_q[idx] == S_CMT) &&
            addr_q[idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2] &&
            |(mask_q[idx] & ld_rmask)) begin
          match      = 1'b1;
          match_mask = mask_q[idx];
          match_data = data_q[idx];
        end
      end
    end
  end

  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = '0;
    ld_stall    = 1'b0;
    if (ld_valid) begin
      if (any_wait) begin
        ld_stall = 1'b1;
      end else if (match) begin
        if ((match_mask & ld_rmask) == ld_rmask) begin
          ld_fwd_hit  = 1'b1;
          ld_fwd_data = match_data;
        end else begin
          ld_stall = 1'b1;
        end
      end
    end
  end

  agu_target_waiting: assert property (@(posedge clk) disable iff (rst)
    agu_valid |-> state_q[agu_idx] == S_WAIT);
  commit_target_ready: assert property (@(posedge clk) disable iff (rst)
    commit_valid |-> state_q[cmt_idx] == S_READY);

endmodule
